// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: funct encoding, funct width and
// arbiter FSM state encodings.
package alu_arbiter_pkg;

  localparam int ALU_FUNCT_WIDTH = 4;

  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_XOR = 4'd4;

  typedef enum logic [1:0] {
    ALU_ARB_IDLE = 2'd0,
    ALU_ARB_EXEC = 2'd1,
    ALU_ARB_RESP = 2'd2
  } arb_state_e;

  // Round-robin successor of a requester index, wrapping at nreq.
  function automatic int rr_next(input int idx, input int nreq);
    if (idx >= nreq - 1) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Reusable round-robin selector: picks the first asserted request at or after the
// pointer, wrapping modulo NREQ. Produces a one-hot grant and its encoded index.
module alu_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_pos;
  logic            w_found;
  int              w_sum;

  // Scan requesters in priority order starting from the pointer.
  always_comb begin
    w_grant = {NREQ{1'b0}};
    w_idx   = {IDW{1'b0}};
    w_pos   = {IDW{1'b0}};
    w_found = 1'b0;
    w_sum   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= NREQ) begin
        w_sum = w_sum - NREQ;
      end else begin
        w_sum = w_sum;
      end
      w_pos = IDW'(w_sum);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        w_grant[w_pos] = 1'b1;
        w_idx          = w_pos;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_any   = w_found;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin accept,
// registered ALU operands, one-cycle execute, registered response with backpressure.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*N-1:0]               req_x,
  input  logic [NREQ*N-1:0]               req_y,
  input  logic [NREQ*ALU_FUNCT_WIDTH-1:0] req_funct,
  output logic [N-1:0]                    alu_x,
  output logic [N-1:0]                    alu_y,
  output logic [ALU_FUNCT_WIDTH-1:0]      alu_funct,
  input  logic [N-1:0]                    alu_z,
  input  logic                            alu_equal,
  input  logic                            alu_zero,
  input  logic                            alu_overflow,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [IDW-1:0]                  resp_id,
  output logic [N-1:0]                    resp_z,
  output logic                            resp_equal,
  output logic                            resp_zero,
  output logic                            resp_overflow
);

  arb_state_e                 r_state;
  logic [IDW-1:0]             r_ptr;
  logic [IDW-1:0]             r_id;
  logic [N-1:0]               r_alu_x;
  logic [N-1:0]               r_alu_y;
  logic [ALU_FUNCT_WIDTH-1:0] r_alu_funct;
  logic                       r_resp_valid;
  logic [IDW-1:0]             r_resp_id;
  logic [N-1:0]               r_resp_z;
  logic                       r_resp_equal;
  logic                       r_resp_zero;
  logic                       r_resp_overflow;

  logic                       w_idle;
  logic [NREQ-1:0]            w_req_gated;
  logic [NREQ-1:0]            w_grant;
  logic [IDW-1:0]             w_idx;
  logic                       w_any;
  logic [IDW-1:0]             w_ptr_nxt;
  logic [N-1:0]               w_x_arr [NREQ];
  logic [N-1:0]               w_y_arr [NREQ];
  logic [ALU_FUNCT_WIDTH-1:0] w_f_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_x_arr[gi] = req_x[gi*N +: N];
    assign w_y_arr[gi] = req_y[gi*N +: N];
    assign w_f_arr[gi] = req_funct[gi*ALU_FUNCT_WIDTH +: ALU_FUNCT_WIDTH];
  end

  assign w_idle      = (r_state == ALU_ARB_IDLE);
  assign w_req_gated = req_valid & {NREQ{w_idle}};
  assign w_ptr_nxt   = IDW'(rr_next(int'(w_idx), NREQ));

  alu_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_req   (w_req_gated),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Ready must read zero while reset is held even though the FSM sits in IDLE.
  assign req_ready = w_grant & {NREQ{rst_n}};

  // Arbiter FSM: accept in IDLE, settle ALU in EXEC, hold response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ALU_ARB_IDLE;
      r_ptr           <= {IDW{1'b0}};
      r_id            <= {IDW{1'b0}};
      r_alu_x         <= {N{1'b0}};
      r_alu_y         <= {N{1'b0}};
      r_alu_funct     <= {ALU_FUNCT_WIDTH{1'b0}};
      r_resp_valid    <= 1'b0;
      r_resp_id       <= {IDW{1'b0}};
      r_resp_z        <= {N{1'b0}};
      r_resp_equal    <= 1'b0;
      r_resp_zero     <= 1'b0;
      r_resp_overflow <= 1'b0;
    end else begin
      case (r_state)
        ALU_ARB_IDLE: begin
          if (w_any) begin
            r_alu_x     <= w_x_arr[w_idx];
            r_alu_y     <= w_y_arr[w_idx];
            r_alu_funct <= w_f_arr[w_idx];
            r_id        <= w_idx;
            r_ptr       <= w_ptr_nxt;
            r_state     <= ALU_ARB_EXEC;
          end else begin
            r_state <= ALU_ARB_IDLE;
          end
        end
        ALU_ARB_EXEC: begin
          r_resp_z        <= alu_z;
          r_resp_equal    <= alu_equal;
          r_resp_zero     <= alu_zero;
          r_resp_overflow <= alu_overflow;
          r_resp_id       <= r_id;
          r_resp_valid    <= 1'b1;
          r_state         <= ALU_ARB_RESP;
        end
        ALU_ARB_RESP: begin
          // No accept here: IDLE is always revisited before the next grant.
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ALU_ARB_IDLE;
          end else begin
            r_state <= ALU_ARB_RESP;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= ALU_ARB_IDLE;
        end
      endcase
    end
  end

  assign alu_x         = r_alu_x;
  assign alu_y         = r_alu_y;
  assign alu_funct     = r_alu_funct;
  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_resp_id;
  assign resp_z        = r_resp_z;
  assign resp_equal    = r_resp_equal;
  assign resp_zero     = r_resp_zero;
  assign resp_overflow = r_resp_overflow;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, transaction-level arbiter
// model checked every cycle, directed vector table and corner-case sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int FW   = ALU_FUNCT_WIDTH;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*N-1:0]    req_x;
  logic [NREQ*N-1:0]    req_y;
  logic [NREQ*FW-1:0]   req_funct;
  logic [N-1:0]         alu_x;
  logic [N-1:0]         alu_y;
  logic [FW-1:0]        alu_funct;
  logic [N-1:0]         alu_z;
  logic                 alu_equal;
  logic                 alu_zero;
  logic                 alu_overflow;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [N-1:0]         resp_z;
  logic                 resp_equal;
  logic                 resp_zero;
  logic                 resp_overflow;

  alu_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_funct(req_funct),
    .alu_x(alu_x), .alu_y(alu_y), .alu_funct(alu_funct),
    .alu_z(alu_z), .alu_equal(alu_equal), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_z(resp_z), .resp_equal(resp_equal), .resp_zero(resp_zero),
    .resp_overflow(resp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] z;
    logic         eq;
    logic         zero;
    logic         ovf;
  } alu_out_t;

  function automatic alu_out_t alu_ref(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic [FW-1:0] f);
    alu_out_t r;
    r.z   = '0;
    r.ovf = 1'b0;
    case (f)
      ALU_ADD: begin r.z = x + y; r.ovf = (x[N-1] == y[N-1]) && (r.z[N-1] != x[N-1]); end
      ALU_SUB: begin r.z = x - y; r.ovf = (x[N-1] != y[N-1]) && (r.z[N-1] != x[N-1]); end
      ALU_AND: r.z = x & y;
      ALU_OR:  r.z = x | y;
      ALU_XOR: r.z = x ^ y;
      default: r.z = '0;
    endcase
    r.eq   = (x == y);
    r.zero = (r.z == '0);
    return r;
  endfunction

  alu_out_t w_alu;
  always_comb begin
    w_alu        = alu_ref(alu_x, alu_y, alu_funct);
    alu_z        = w_alu.z;
    alu_equal    = w_alu.eq;
    alu_zero     = w_alu.zero;
    alu_overflow = w_alu.ovf;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: one op outstanding; age counts cycles since accept.
  int           m_ptr  = 0;
  bit           m_busy = 1'b0;
  int           m_age  = 0;
  int           m_id   = 0;
  logic [N-1:0] m_x, m_y;
  logic [FW-1:0] m_f;
  int           cyc = 0;
  int           obs_id[$];
  int           obs_cyc[$];

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Inputs are set before the call (posedge+1); checks at negedge, model advances at posedge.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_ready;
    logic exp_rv;
    alu_out_t r;
    @(negedge clk);
    cyc++;
    g = m_busy ? -1 : pick(req_valid, m_ptr);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    exp_rv = m_busy && (m_age >= 2);
    chk("resp_valid", resp_valid, exp_rv);
    if (m_busy && m_age == 1) begin
      chk("alu_x", alu_x, m_x);
      chk("alu_y", alu_y, m_y);
      chk("alu_funct", alu_funct, m_f);
    end
    if (exp_rv) begin
      r = alu_ref(m_x, m_y, m_f);
      chk("resp_z", resp_z, r.z);
      chk("resp_id", resp_id, m_id);
      chk("resp_equal", resp_equal, r.eq);
      chk("resp_zero", resp_zero, r.zero);
      chk("resp_overflow", resp_overflow, r.ovf);
      if (resp_ready) begin
        obs_id.push_back(int'(resp_id));
        obs_cyc.push_back(cyc);
      end
    end
    if (g >= 0) begin
      m_busy = 1'b1;
      m_age  = 1;
      m_id   = g;
      m_x    = req_x[g*N +: N];
      m_y    = req_y[g*N +: N];
      m_f    = req_funct[g*FW +: FW];
      m_ptr  = (g + 1) % NREQ;
    end else if (m_busy) begin
      if (exp_rv && resp_ready) m_busy = 1'b0;
      else if (m_age < 2) m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [FW-1:0] f);
    req_x[i*N +: N]     = x;
    req_y[i*N +: N]     = y;
    req_funct[i*FW +: FW] = f;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) cycle();
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic [FW-1:0] f;
    logic [N-1:0]  z;
    logic          zero;
    logic          eq;
    logic          ovf;
  } vec_t;

  vec_t vecs[9];
  logic [N-1:0] snap_z;
  logic [IDW-1:0] snap_id;
  logic [2:0] snap_fl;

  initial begin
    vecs[0] = '{32'd5,          32'd7,          ALU_ADD, 32'd12,         1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF,  32'd1,          ALU_ADD, 32'h8000_0000,  1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'd9,          32'd9,          ALU_SUB, 32'd0,          1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'd3,          32'd5,          ALU_SUB, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000,  32'd1,          ALU_SUB, 32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_F0F0,  32'h0000_FF00,  ALU_AND, 32'h0000_F000,  1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  ALU_XOR, 32'd0,          1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h1234_0000,  32'h0000_5678,  ALU_OR,  32'h1234_5678,  1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'hFFFF_FFFF,  32'd1,          ALU_ADD, 32'd0,          1'b1, 1'b0, 1'b0};

    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_x      = '0;
    req_y      = '0;
    req_funct  = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_alu_x", alu_x, 32'd0);
    chk("rst_resp_z", resp_z, 32'd0);
    chk("rst_resp_id", resp_id, 1'b0);
    req_valid = '0;
    rst_n     = 1'b1;
    cycle();

    // Directed vectors through requester 0: accept, execute, respond at T+2.
    for (int v = 0; v < 9; v++) begin
      set_req(0, vecs[v].x, vecs[v].y, vecs[v].f);
      req_valid  = 2'b01;
      resp_ready = 1'b0;
      cycle();
      req_valid = '0;
      set_req(0, $urandom, $urandom, FW'($urandom_range(0, 4)));
      cycle();
      chk("vec_resp_valid", resp_valid, 1'b1);
      chk("vec_resp_z", resp_z, vecs[v].z);
      chk("vec_resp_id", resp_id, 1'b0);
      chk("vec_resp_zero", resp_zero, vecs[v].zero);
      chk("vec_resp_equal", resp_equal, vecs[v].eq);
      chk("vec_resp_overflow", resp_overflow, vecs[v].ovf);
      resp_ready = 1'b1;
      cycle();
      resp_ready = 1'b0;
    end

    // Reset while holding a response; pointer is 1 going in.
    set_req(0, 32'd1, 32'd2, ALU_ADD);
    req_valid = 2'b01;
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    chk("pre_rst_resp_valid", resp_valid, 1'b1);
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 2'b00);
    m_busy = 1'b0;
    m_age  = 0;
    m_ptr  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention: both valid, consumer always ready.
    set_req(0, 32'd100, 32'd1, ALU_ADD);
    set_req(1, 32'd50,  32'd8, ALU_SUB);
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    obs_id.delete();
    obs_cyc.delete();
    repeat (12) cycle();
    chk("cont_nresp", obs_id.size(), 4);
    if (obs_id.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("cont_id", obs_id[k], k % 2);
      for (int k = 1; k < 4; k++) chk("cont_gap", obs_cyc[k] - obs_cyc[k-1], 3);
    end
    req_valid = '0;
    cycle();

    // Backpressure: response held for 5 cycles with both requesters waiting.
    set_req(0, 32'h7FFF_FFFF, 32'd1, ALU_ADD);
    req_valid  = 2'b01;
    resp_ready = 1'b0;
    cycle();
    req_valid = 2'b11;
    cycle();
    snap_z  = resp_z;
    snap_id = resp_id;
    snap_fl = {resp_equal, resp_zero, resp_overflow};
    chk("bp_z", snap_z, 32'h8000_0000);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_hold_z", resp_z, snap_z);
      chk("bp_hold_id", resp_id, snap_id);
      chk("bp_hold_flags", {resp_equal, resp_zero, resp_overflow}, snap_fl);
      chk("bp_ready_zero", req_ready, 2'b00);
    end
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    chk("bp_next_grant", req_ready, 2'b10);
    cycle();
    drain();

    // Operand change right after the handshake must not affect the op in flight.
    set_req(1, 32'd100, 32'd23, ALU_SUB);
    req_valid = 2'b10;
    cycle();
    set_req(1, 32'd999, 32'd1, ALU_ADD);
    req_valid = '0;
    cycle();
    chk("opchg_valid", resp_valid, 1'b1);
    chk("opchg_z", resp_z, 32'd77);
    chk("opchg_id", resp_id, 1'b1);
    resp_ready = 1'b1;
    cycle();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom_range(0, 3));
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 0) set_req(i, $urandom_range(0, 3), $urandom_range(0, 3),
                                               FW'($urandom_range(0, 4)));
        else set_req(i, $urandom, $urandom, FW'($urandom_range(0, 4)));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
